unidad_control_mc: RTL

//  Multi-cycle control unit for the single-cycle 8-bit microcontroller datapath.

---
 rtl/uc_pkg.sv | 32 +++
 rtl/uc_decoder.sv | 42 ++++
 rtl/unidad_control_mc.sv | 100 ++++++++++
 3 files changed

// File: rtl/uc_pkg.sv
// Package for the multi-cycle control unit.
// Holds the FSM state encoding, the opcode constants and the decoded
// control-vector type shared by the decoder and the top level.
package uc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // LI ignores the two low opcode bits, so only its 4-bit prefix is matched.
    localparam logic [3:0] OPC_LI   = 4'b1000;
    localparam logic [5:0] OPC_J    = 6'b100100;
    localparam logic [5:0] OPC_JZ   = 6'b100101;
    localparam logic [5:0] OPC_JNZ  = 6'b100110;
    localparam logic [5:0] OPC_HALT = 6'b100111;
    localparam logic [5:0] OPC_NOP  = 6'b101000;

    typedef struct packed {
        logic       pc_en;
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op;
        logic       halt;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/uc_decoder.sv
// Combinational opcode decoder for the control unit.
// Ports:
//   opcode  in   6  instruc[15:10] from the datapath
//   z       in   1  registered zero flag
//   ctrl    out     control vector valid for an EXEC cycle
module uc_decoder
    import uc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       z,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl       = '0;
        ctrl.pc_en = 1'b1;
        ctrl.s_inc = 1'b1;
        if (!opcode[5]) begin
            // ALU class: operation select comes straight from the opcode.
            ctrl.op  = opcode[4:2];
            ctrl.we3 = 1'b1;
            ctrl.wez = 1'b1;
        end else if (opcode[5:2] == OPC_LI) begin
            ctrl.we3   = 1'b1;
            ctrl.s_inm = 1'b1;
        end else begin
            case (opcode)
                OPC_J:    ctrl.s_inc = 1'b0;
                OPC_JZ:   ctrl.s_inc = ~z;
                OPC_JNZ:  ctrl.s_inc = z;
                OPC_HALT: begin
                    ctrl.pc_en = 1'b0;
                    ctrl.halt  = 1'b1;
                end
                OPC_NOP:  ctrl.s_inc = 1'b1;
                // Undefined opcodes behave as NOP but are flagged.
                default:  ctrl.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/unidad_control_mc.sv
// Multi-cycle control unit for the 8-bit microcontroller datapath.
// Every instruction takes FETCH + EXEC so the synchronous program memory
// has a full cycle to present the opcode. Also sequences start/halt and
// counts retired instructions.
// Ports:
//   clk      in   1      system clock
//   reset    in   1      synchronous active-low reset
//   go       in   1      start execution from IDLE
//   opcode   in   6      instruc[15:10]
//   z        in   1      registered zero flag
//   pc_en    out  1      PC load enable
//   s_inc    out  1      1 = PC+1, 0 = jump target
//   s_inm    out  1      1 = write immediate, 0 = ALU result
//   we3      out  1      register-file write enable
//   wez      out  1      zero-flag load enable
//   op       out  3      ALU operation
//   halted   out  1      high while halted
//   illegal  out  1      pulse in EXEC of an undefined opcode
//   retired  out  CNT_W  instructions completed since reset
module unidad_control_mc
    import uc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [5:0]       opcode,
    input  logic             z,
    output logic             pc_en,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       op,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q;
    logic [CNT_W-1:0] retired_q;
    logic             halted_q;
    ctrl_t            dec;

    uc_decoder u_decoder (
        .opcode (opcode),
        .z      (z),
        .ctrl   (dec)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            retired_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (go) state_q <= ST_FETCH;
                ST_FETCH: state_q <= ST_EXEC;
                ST_EXEC: begin
                    if (dec.halt) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q   <= ST_FETCH;
                        retired_q <= retired_q + 1'b1;
                    end
                end
                ST_HALT:  state_q <= ST_HALT;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // Decoded controls are only exposed in EXEC; write enables are gated by
    // reset so a reset landing mid-EXEC never disturbs the datapath.
    always_comb begin
        pc_en   = 1'b0;
        s_inc   = 1'b1;
        s_inm   = 1'b0;
        we3     = 1'b0;
        wez     = 1'b0;
        op      = 3'b000;
        illegal = 1'b0;
        if (state_q == ST_EXEC) begin
            pc_en   = dec.pc_en & reset;
            s_inc   = dec.s_inc;
            s_inm   = dec.s_inm;
            we3     = dec.we3 & reset;
            wez     = dec.wez & reset;
            op      = dec.op;
            illegal = dec.illegal;
        end
    end

    assign halted  = halted_q;
    assign retired = retired_q;

endmodule
